// File: rtl/timer_dev.sv
// ============================================================================
// timer_dev : memory-mapped countdown timer (CTRL/PRESET/COUNT) with irq.
// Optional: `define TIMER_AUTO_RELOAD_EN enables MODE 1 auto-reload. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module timer_dev #(
  parameter int unsigned PRESCALE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADDR_PRESET = 2'd1;
  localparam logic [1:0] C_ADDR_COUNT  = 2'd2;
  localparam logic [7:0] C_PRESCALE    = 8'(PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  presc_q, presc_d;
  logic        flag_q, flag_d;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_tick;
  logic w_auto_reload;
  logic w_flag_set;
  logic w_flag_clr;

  assign w_wr_ctrl   = we && (addr == C_ADDR_CTRL);
  assign w_wr_preset = we && (addr == C_ADDR_PRESET);
  assign w_tick      = (presc_q == C_PRESCALE);

  // MODE bits are always stored; only the reload decode depends on the build.
`ifdef TIMER_AUTO_RELOAD_EN
  assign w_auto_reload = (mode_q == 2'd1);
`else
  assign w_auto_reload = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    presc_d    = presc_q;
    w_flag_set = 1'b0;
    w_flag_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        presc_d = 8'd0;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (w_tick) begin
          presc_d = 8'd0;
          if (count_q <= 32'd1) begin
            count_d    = 32'd0;
            w_flag_set = 1'b1;
            state_d    = S_INT;
          end else begin
            count_d = count_q - 32'd1;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_INT: begin
        if (w_auto_reload) begin
          w_flag_clr = 1'b1;
          state_d    = S_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes come last so a CTRL write overrides the one-shot EN clear.
    if (w_wr_ctrl) begin
      en_d   = wdata[0];
      mode_d = wdata[2:1];
      im_d   = wdata[3];
    end
    if (w_wr_preset) preset_d = wdata;

    flag_d = w_flag_set | (flag_q & ~(w_flag_clr | w_wr_ctrl | w_wr_preset));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      presc_q  <= 8'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      C_ADDR_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      C_ADDR_PRESET: rdata = preset_q;
      C_ADDR_COUNT:  rdata = count_q;
      default:       rdata = 32'd0;
    endcase
  end

  assign irq = im_q & flag_q;

endmodule

`default_nettype wire
